// File: rtl/arb2in1_pkg.sv
// arb2in1_pkg: arbiter state encodings and the two-requester priority pick
package arb2in1_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;
  function automatic arb_state_t arb_pick(input logic r0, input logic r1, input logic lst);
    return (r0 && r1) ? (lst ? ARB_OWN0 : ARB_OWN1) : r0 ? ARB_OWN0 : r1 ? ARB_OWN1 : ARB_IDLE;
  endfunction
endpackage

// File: rtl/arb2in1.sv
// arb2in1: round-robin req/gnt/ack arbiter for one shared port (i_clk, i_rst sync high; i_req0/1, i_ack in; o_gnt0/1, o_control, o_busy, o_timeout out)
module arb2in1
  import arb2in1_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ack,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_control,
  output logic o_busy,
  output logic o_timeout
);
  arb_state_t state, next_state;
  logic last, next_last, next_ctrl;
  logic own, owner, own_req, expire, rel, expired, grant_new;
  logic [TO_W-1:0] cnt;
  always_comb begin
    own        = state != ARB_IDLE;
    owner      = state == ARB_OWN1;
    own_req    = owner ? i_req1 : i_req0;
    expire     = cnt == TO_W'(TIMEOUT - 1);
    rel        = own && (i_ack || !own_req || expire);
    expired    = own && !i_ack && expire;
    next_last  = rel ? owner : last;
    // on release the owner becomes "last", so it loses any tie
    next_state = own ? (rel ? arb_pick(i_req0, i_req1, owner) : state)
                     : arb_pick(i_req0, i_req1, last);
    grant_new  = (next_state != ARB_IDLE) && (!own || rel);
    next_ctrl  = grant_new ? (next_state == ARB_OWN1) : o_control;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ARB_IDLE;
      last      <= 1'b1;
      o_control <= 1'b0;
    end else begin
      state     <= next_state;
      last      <= next_last;
      o_control <= next_ctrl;
    end
  end
  // watchdog: restarts on every new grant, saturates while unacknowledged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      cnt       <= grant_new ? '0 : (own && cnt != '1) ? cnt + 1'b1 : cnt;
      o_timeout <= expired;
    end
  end
  assign o_gnt0 = state == ARB_OWN0;
  assign o_gnt1 = state == ARB_OWN1;
  assign o_busy = own;
endmodule
